pipeline_stall_controller: RTL and testbench

Sequences pipeline advance for the 5-stage MIPS core, with branches resolved in Decode. Consumes the hazard unit's FlushSignal, decode-stage branch/jump outcomes and a multi-cycle mul/div handshake. Drives PC write enable, IF/ID write/flush and the ID/EX bubble select. Keeps saturating stall/flush performance counters and sticky error flags.

---
 rtl/pipeline_stall_controller_if.sv | 31 +++
 rtl/pipeline_stall_controller.sv | 116 +++++++++++
 tb/tb_pipeline_stall_controller.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_stall_controller_if.sv
// Handshake bundle between the stall controller and the MIPS pipeline datapath.
interface pipeline_stall_controller_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 HazardFlush;
  logic                 ID_BranchTaken;
  logic                 ID_Jump;
  logic                 ID_MulDiv;
  logic                 MD_Done;
  logic                 MD_Start;
  logic                 PCWrite;
  logic                 IF_ID_Write;
  logic                 IF_ID_Flush;
  logic                 ID_EX_Bubble;
  logic [CNT_WIDTH-1:0] StallCount;
  logic [CNT_WIDTH-1:0] FlushCount;
  logic                 HazErr;
  logic                 Timeout;

  modport slave (
    input  HazardFlush, ID_BranchTaken, ID_Jump, ID_MulDiv, MD_Done,
    output MD_Start, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble,
           StallCount, FlushCount, HazErr, Timeout
  );

  modport master (
    output HazardFlush, ID_BranchTaken, ID_Jump, ID_MulDiv, MD_Done,
    input  MD_Start, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble,
           StallCount, FlushCount, HazErr, Timeout
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Pipeline advance sequencer: data-hazard stalls, multi-cycle mul/div waits and
// decode-stage branch squash, with saturating perf counters and sticky error flags.
module pipeline_stall_controller #(
  parameter int MAX_DATA_STALL = 2,
  parameter int MD_TIMEOUT     = 64,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                        Clk,
  input  logic                        Rst_n,
  pipeline_stall_controller_if.slave  bus
);
  localparam int DW = $clog2(MAX_DATA_STALL + 2);
  localparam int MW = $clog2(MD_TIMEOUT + 1);
  localparam logic [DW-1:0] DMAX  = DW'(MAX_DATA_STALL);
  localparam logic [MW-1:0] MLAST = MW'(MD_TIMEOUT - 1);

  typedef enum logic [1:0] {S_RUN, S_DSTALL, S_MDWAIT} state_t;

  state_t               r_state, w_state_nxt;
  logic [DW-1:0]        r_dcnt, w_dcnt_nxt;
  logic [MW-1:0]        r_mcnt, w_mcnt_nxt;
  logic                 r_md_start, r_herr, r_tout;
  logic [CNT_WIDTH-1:0] r_stall_cnt, r_flush_cnt;
  logic                 w_pcwrite, w_ifid_write, w_flush, w_bubble;
  logic                 w_launch, w_herr_set, w_tout_set;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= S_RUN;
      r_dcnt      <= '0;
      r_mcnt      <= '0;
      r_md_start  <= 1'b0;
      r_herr      <= 1'b0;
      r_tout      <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_dcnt     <= w_dcnt_nxt;
      r_mcnt     <= w_mcnt_nxt;
      r_md_start <= w_launch;
      if (w_herr_set) r_herr <= 1'b1;
      if (w_tout_set) r_tout <= 1'b1;
      if (!w_pcwrite && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush && !(&r_flush_cnt))    r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_dcnt_nxt   = r_dcnt;
    w_mcnt_nxt   = r_mcnt;
    w_pcwrite    = 1'b1;
    w_ifid_write = 1'b1;
    w_flush      = 1'b0;
    w_bubble     = 1'b0;
    w_launch     = 1'b0;
    w_herr_set   = 1'b0;
    w_tout_set   = 1'b0;
    case (r_state)
      S_MDWAIT: begin
        // r_mcnt counts wait cycles already spent, so MLAST marks the final allowed one
        w_mcnt_nxt = r_mcnt + 1'b1;
        if (bus.MD_Done) begin
          w_state_nxt = S_RUN;
        end else if (r_mcnt == MLAST) begin
          w_state_nxt = S_RUN;
          w_tout_set  = 1'b1;
        end else begin
          w_pcwrite    = 1'b0;
          w_ifid_write = 1'b0;
          w_bubble     = 1'b1;
        end
      end
      default: begin
        // DSTALL with the hazard cleared releases under RUN rules in the same cycle
        if (bus.HazardFlush) begin
          w_pcwrite    = 1'b0;
          w_ifid_write = 1'b0;
          w_bubble     = 1'b1;
          w_state_nxt  = S_DSTALL;
          if (r_state == S_DSTALL) w_dcnt_nxt = (&r_dcnt) ? r_dcnt : r_dcnt + 1'b1;
          else                     w_dcnt_nxt = DW'(1);
          w_herr_set = (w_dcnt_nxt > DMAX);
        end else if (bus.ID_MulDiv) begin
          w_pcwrite    = 1'b0;
          w_ifid_write = 1'b0;
          w_bubble     = 1'b1;
          w_launch     = 1'b1;
          w_state_nxt  = S_MDWAIT;
          w_mcnt_nxt   = '0;
        end else begin
          w_state_nxt = S_RUN;
          w_flush     = bus.ID_BranchTaken | bus.ID_Jump;
        end
      end
    endcase
    if (!Rst_n) begin
      w_pcwrite    = 1'b0;
      w_ifid_write = 1'b0;
      w_flush      = 1'b0;
      w_bubble     = 1'b1;
      w_launch     = 1'b0;
    end
  end

  assign bus.MD_Start     = r_md_start;
  assign bus.PCWrite      = w_pcwrite;
  assign bus.IF_ID_Write  = w_ifid_write;
  assign bus.IF_ID_Flush  = w_flush;
  assign bus.ID_EX_Bubble = w_bubble;
  assign bus.StallCount   = r_stall_cnt;
  assign bus.FlushCount   = r_flush_cnt;
  assign bus.HazErr       = r_herr;
  assign bus.Timeout      = r_tout;
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed + randomized bench for pipeline_stall_controller against a cycle-level
// behavioural model of the stall/flush rules.
module tb_pipeline_stall_controller;
  localparam int MAXD = 2;
  localparam int MDT  = 64;
  localparam int CW   = 6;
  localparam int SAT  = (1 << CW) - 1;

  logic Clk, Rst_n;
  int   checks = 0;
  int   errors = 0;

  // behavioural model state
  bit m_md_busy;
  int m_md_cycles;
  int m_streak;
  bit m_start;
  int m_stall, m_flush;
  bit m_herr, m_tout;

  pipeline_stall_controller_if #(.CNT_WIDTH(CW)) bus ();

  pipeline_stall_controller #(
    .MAX_DATA_STALL(MAXD), .MD_TIMEOUT(MDT), .CNT_WIDTH(CW)
  ) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_md_busy = 0; m_md_cycles = 0; m_streak = 0; m_start = 0;
    m_stall = 0; m_flush = 0; m_herr = 0; m_tout = 0;
  endtask

  // Async reset asserted wherever we are, outputs checked while held, released after 2 edges
  task automatic apply_reset();
    Rst_n = 1'b0;
    #2;
    chk("rst_PCWrite", bus.PCWrite, 0);
    chk("rst_IF_ID_Write", bus.IF_ID_Write, 0);
    chk("rst_IF_ID_Flush", bus.IF_ID_Flush, 0);
    chk("rst_Bubble", bus.ID_EX_Bubble, 1);
    chk("rst_MD_Start", bus.MD_Start, 0);
    chk("rst_StallCount", bus.StallCount, 0);
    chk("rst_FlushCount", bus.FlushCount, 0);
    chk("rst_HazErr", bus.HazErr, 0);
    chk("rst_Timeout", bus.Timeout, 0);
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    model_clear();
  endtask

  // One clock cycle: drive inputs, compare, advance the model, cross the edge
  task automatic step(input int hf, input int br, input int jp, input int md, input int dn);
    bit e_pcw, e_ifw, e_fl, e_bub, rel;
    bus.HazardFlush    = (hf != 0);
    bus.ID_BranchTaken = (br != 0);
    bus.ID_Jump        = (jp != 0);
    bus.ID_MulDiv      = (md != 0);
    bus.MD_Done        = (dn != 0);
    #2;
    chk("MD_Start", bus.MD_Start, m_start);
    chk("StallCount", bus.StallCount, m_stall);
    chk("FlushCount", bus.FlushCount, m_flush);
    chk("HazErr", bus.HazErr, m_herr);
    chk("Timeout", bus.Timeout, m_tout);
    e_fl = 0;
    if (m_md_busy) begin
      m_md_cycles++;
      rel = (dn != 0) || (m_md_cycles == MDT);
      if (rel && dn == 0) m_tout = 1;
      if (rel) m_md_busy = 0;
      e_pcw = rel; e_ifw = rel; e_bub = !rel;
      m_start = 0; m_streak = 0;
    end else if (hf != 0) begin
      e_pcw = 0; e_ifw = 0; e_bub = 1;
      m_streak++;
      if (m_streak > MAXD) m_herr = 1;
      m_start = 0;
    end else if (md != 0) begin
      e_pcw = 0; e_ifw = 0; e_bub = 1;
      m_md_busy = 1; m_md_cycles = 0; m_start = 1; m_streak = 0;
    end else begin
      e_pcw = 1; e_ifw = 1; e_bub = 0;
      e_fl = (br != 0) || (jp != 0);
      m_start = 0; m_streak = 0;
    end
    chk("PCWrite", bus.PCWrite, e_pcw);
    chk("IF_ID_Write", bus.IF_ID_Write, e_ifw);
    chk("IF_ID_Flush", bus.IF_ID_Flush, e_fl);
    chk("ID_EX_Bubble", bus.ID_EX_Bubble, e_bub);
    if (!e_pcw && m_stall < SAT) m_stall++;
    if (e_fl && m_flush < SAT)   m_flush++;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    Rst_n = 1'b0;
    bus.HazardFlush = 0; bus.ID_BranchTaken = 0; bus.ID_Jump = 0;
    bus.ID_MulDiv = 0; bus.MD_Done = 0;
    model_clear();
    @(posedge Clk);
    #1;
    apply_reset();

    // idle after reset
    idle(5);
    chk("idle_StallCount", bus.StallCount, 0);

    // two-cycle hazard stays within the limit, three cycles trips HazErr
    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    chk("haz2_StallCount", bus.StallCount, 2);
    chk("haz2_HazErr", bus.HazErr, 0);
    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
    idle(3);
    chk("haz3_HazErr", bus.HazErr, 1);

    // mul/div finishing 10 cycles after MD_Start; MD_Done in RUN is ignored
    apply_reset();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0);
    for (int k = 0; k < 10; k++) step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    idle(2);
    chk("md10_StallCount", bus.StallCount, 11);
    chk("md10_Timeout", bus.Timeout, 0);

    // mul/div never completes: abandoned on the 64th wait cycle
    step(0, 0, 0, 1, 0);
    for (int k = 0; k < MDT; k++) step(0, 0, 0, 0, 0);
    idle(2);
    chk("mdto_Timeout", bus.Timeout, 1);

    // MD_Done on the 64th wait cycle wins over the timeout
    apply_reset();
    step(0, 0, 0, 1, 0);
    for (int k = 0; k < MDT - 1; k++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    idle(2);
    chk("md64_Timeout", bus.Timeout, 0);

    // hazard masks a taken branch, then the branch squashes on release; jump too
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("br_FlushCount", bus.FlushCount, 1);
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    idle(2);

    // reset in the middle of a mul/div wait, and right as MD_Start is pulsing
    step(0, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0);
    apply_reset();
    idle(4);
    step(0, 0, 0, 1, 0);
    apply_reset();
    idle(4);

    // randomized traffic in several reset windows
    for (int blk = 0; blk < 4; blk++) begin
      for (int n = 0; n < 200; n++) begin
        step(($urandom_range(0, 99) < 25) ? 1 : 0,
             ($urandom_range(0, 99) < 20) ? 1 : 0,
             ($urandom_range(0, 99) < 8)  ? 1 : 0,
             ($urandom_range(0, 99) < 6)  ? 1 : 0,
             ($urandom_range(0, 99) < 10) ? 1 : 0);
      end
      apply_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
